// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   CPU-side initiator for the block-RAM data memory port. It takes load and
//   store requests from the execute stage over a valid/ready handshake. It
//   drives the RAM strobes and absorbs the RAM's one-cycle registered read
//   latency. Each accepted request produces exactly one resp_valid pulse.
//
//   Optional feature macro: MEM_BYTE_ACCESS_EN
//     When this macro is defined, req_addr is a byte address and memaddr is
//     req_addr >> 1. Byte loads return the selected lane, zero-extended.
//     Byte stores perform a read-modify-write through the MERGE state.
//     When it is undefined, req_addr is a word address, req_byte is ignored,
//     and every access is a word access.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     request present
//   req_ready     unit idle and able to accept
//   req_write     1 = store, 0 = load
//   req_byte      byte access (feature build only)
//   req_addr      request address
//   req_data      store data
//   resp_valid    one-cycle pulse: load data valid / store complete
//   resp_data     last load result, held until the next load completes
//   memaddr       RAM address (full width; the RAM wraps on its low bits)
//   memval        RAM write data
//   memget        RAM read strobe
//   memset        RAM write enable
//   memout        RAM read data, valid the cycle after memget
//
// Every output comes from a flop. The output-decode process computes the
// value each output takes after the next edge. The state-register process
// loads those values.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_byte,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_data,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic [WORD_SIZE-1:0] memaddr,
  output logic [WORD_SIZE-1:0] memval,
  output logic                 memget,
  output logic                 memset,
  input  logic [WORD_SIZE-1:0] memout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    CAPTURE = 3'd3
`ifdef MEM_BYTE_ACCESS_EN
   ,MERGE   = 3'd4
`endif
  } state_t;

  state_t state, next_state;

  logic                 accept;
  logic [WORD_SIZE-1:0] word_addr;
  logic                 byte_op;

  logic                 nxt_ready;
  logic                 nxt_resp_valid;
  logic [WORD_SIZE-1:0] nxt_resp_data;
  logic [WORD_SIZE-1:0] nxt_memaddr;
  logic [WORD_SIZE-1:0] nxt_memval;
  logic                 nxt_memget;
  logic                 nxt_memset;
  logic [WORD_SIZE-1:0] load_result;

  assign accept = req_valid && req_ready;

`ifdef MEM_BYTE_ACCESS_EN
  // Only the fields needed after acceptance are latched. The word address
  // and word store data go straight into memaddr/memval, which hold them.
  typedef struct packed {
    logic       write;
    logic       is_byte;
    logic       lane;
    logic [7:0] bdata;
  } req_t;

  req_t                 lat;
  logic [WORD_SIZE-1:0] merged;

  assign word_addr = req_addr >> 1;
  assign byte_op   = req_byte;

  // Read-modify-write: keep the other lane from the RAM word.
  always_comb begin
    merged = memout;
    if (lat.lane) merged[8 +: 8] = lat.bdata;
    else          merged[0 +: 8] = lat.bdata;
  end

  always_comb begin
    load_result = memout;
    if (lat.is_byte) begin
      load_result = '0;
      load_result[0 +: 8] = lat.lane ? memout[8 +: 8] : memout[0 +: 8];
    end
  end

  // MEM_ADDR_BITS only describes the responder's decode width. Addresses
  // pass through untouched.
  logic unused;
  assign unused = (MEM_ADDR_BITS == 0);
`else
  assign word_addr   = req_addr;
  assign byte_op     = 1'b0;
  assign load_result = memout;

  logic unused;
  assign unused = ^{req_byte, (MEM_ADDR_BITS == 0)};
`endif

  // -------------------------------------------------------------------------
  // State register. It also registers every output.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      memaddr    <= '0;
      memval     <= '0;
      memget     <= 1'b0;
      memset     <= 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
      lat        <= '0;
`endif
    end else begin
      state      <= next_state;
      req_ready  <= nxt_ready;
      resp_valid <= nxt_resp_valid;
      resp_data  <= nxt_resp_data;
      memaddr    <= nxt_memaddr;
      memval     <= nxt_memval;
      memget     <= nxt_memget;
      memset     <= nxt_memset;
`ifdef MEM_BYTE_ACCESS_EN
      if (accept)
        lat <= '{write: req_write, is_byte: req_byte,
                 lane: req_addr[0], bdata: req_data[7:0]};
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // A byte store reads first, so it goes through READ.
        if (accept)
          next_state = (req_write && !byte_op) ? WRITE : READ;
      end
      WRITE:   next_state = IDLE;
`ifdef MEM_BYTE_ACCESS_EN
      // READ only sees a store when that store is a byte store.
      READ:    next_state = lat.write ? MERGE : CAPTURE;
      MERGE:   next_state = WRITE;
`else
      READ:    next_state = CAPTURE;
`endif
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. These are the values the output flops take at the next
  // edge.
  // -------------------------------------------------------------------------
  always_comb begin
    nxt_resp_valid = 1'b0;
    nxt_resp_data  = resp_data;
    nxt_memaddr    = memaddr;
    nxt_memval     = memval;
    nxt_memget     = 1'b0;
    nxt_memset     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_memaddr = word_addr;
          if (req_write && !byte_op) begin
            nxt_memset = 1'b1;
            nxt_memval = req_data;
          end else begin
            nxt_memget = 1'b1;
          end
        end
      end
      // The write strobe is already on the port. Acknowledge as it drops.
      WRITE: nxt_resp_valid = 1'b1;
      // The RAM registers memout at the end of READ, so the data is sampled
      // in CAPTURE.
      CAPTURE: begin
        nxt_resp_valid = 1'b1;
        nxt_resp_data  = load_result;
      end
`ifdef MEM_BYTE_ACCESS_EN
      MERGE: begin
        nxt_memset = 1'b1;
        nxt_memval = merged;
      end
`endif
      default: ;
    endcase
  end

  // Ready is high exactly when the unit will be in IDLE.
  assign nxt_ready = (next_state == IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. It uses a behavioural one-cycle-latency RAM
// and a shadow memory model. Expected responses are queued at acceptance and
// checked when resp_valid pulses.
module tb_mem_access_unit;
  localparam int W = 16;
`ifdef MEM_BYTE_ACCESS_EN
  localparam int ASH     = 1;
  localparam bit BYTE_EN = 1'b1;
`else
  localparam int ASH     = 0;
  localparam bit BYTE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write, req_byte;
  logic [W-1:0] req_addr, req_data;
  logic         resp_valid;
  logic [W-1:0] resp_data, memaddr, memval, memout;
  logic         memget, memset;

  mem_access_unit #(.WORD_SIZE(W), .MEM_ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .memaddr(memaddr), .memval(memval), .memget(memget), .memset(memset),
    .memout(memout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // The RAM responder registers its read data and decodes 10 address bits.
  logic [W-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (memset) ram[memaddr[9:0]] <= memval;
    if (memget) memout <= ram[memaddr[9:0]];
  end

  logic [W-1:0] shadow [0:1023];
  logic [W-1:0] last_load;

  typedef struct {
    bit           wr;
    logic [W-1:0] exp;
    int           acc;
    int           lat;
  } sb_t;
  sb_t sbq[$];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [W-1:0] a);
    logic [W-1:0] s;
    s = (a >> ASH) & 16'h03FF;
    return int'(s);
  endfunction

  // The monitor pops one expectation per response pulse.
  always @(negedge clk) begin : mon
    sb_t e;
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        e = sbq.pop_front();
        chk(e.wr ? "st_latency" : "ld_latency", cyc - e.acc, e.lat);
        chk(e.wr ? "st_data_hold" : "ld_data", resp_data, e.exp);
      end
    end
  end

  // The caller must be at a negedge. The task returns at the negedge of
  // cycle 1, counted from the acceptance edge.
  task automatic send(input bit wr, input bit byt, input logic [W-1:0] a,
                      input logic [W-1:0] d, output int acc);
    int  n;
    int  wi;
    bit  bop;
    sb_t e;
    req_valid = 1'b1; req_write = wr; req_byte = byt; req_addr = a; req_data = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      req_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc;
    wi  = widx(a);
    bop = BYTE_EN && byt;
    e.wr = wr; e.acc = acc;
    if (wr) begin
      if (bop) begin
        if (a[0]) shadow[wi] = {d[7:0], shadow[wi][7:0]};
        else      shadow[wi] = {shadow[wi][15:8], d[7:0]};
        e.lat = 4;
      end else begin
        shadow[wi] = d;
        e.lat = 2;
      end
      e.exp = last_load;
    end else begin
      if (bop) last_load = a[0] ? {8'h00, shadow[wi][15:8]} : {8'h00, shadow[wi][7:0]};
      else     last_load = shadow[wi];
      e.exp = last_load;
      e.lat = 3;
    end
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    chk("drain_timeout", sbq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, c0;
    int wi;
    logic [W-1:0] saved;
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; shadow[i] = '0; end
    last_load = '0;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_data = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memval", memval, 0);
    chk("rst_memget", memget, 0);
    chk("rst_memset", memset, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Store of 0xBEEF to word 5
    send(1, 0, 16'h0005 << ASH, 16'hBEEF, a0);
    chk("st_memset", memset, 1);
    chk("st_memaddr", memaddr, 16'h0005);
    chk("st_memval", memval, 16'hBEEF);
    chk("st_memget", memget, 0);
    chk("st_busy_ready", req_ready, 0);
    @(negedge clk);
    chk("st_memset_1cyc", memset, 0);
    drain();

    // Load from word 5
    send(0, 0, 16'h0005 << ASH, 16'h0000, a0);
    chk("ld_memget", memget, 1);
    chk("ld_memaddr", memaddr, 16'h0005);
    chk("ld_memset", memset, 0);
    @(negedge clk);
    chk("ld_memget_1cyc", memget, 0);
    chk("ld_busy_ready", req_ready, 0);
    drain();

    // Back-to-back stores, then back-to-back loads, with req_valid held high
    send(1, 0, 16'h0001 << ASH, 16'h1111, a0);
    send(1, 0, 16'h0002 << ASH, 16'h2222, a1);
    send(1, 0, 16'h0003 << ASH, 16'h3333, a2);
    chk("st_spacing_a", a1 - a0, 2);
    chk("st_spacing_b", a2 - a1, 2);
    send(0, 0, 16'h0001 << ASH, 16'h0, a0);
    send(0, 0, 16'h0002 << ASH, 16'h0, a1);
    send(0, 0, 16'h0003 << ASH, 16'h0, a2);
    chk("ld_spacing_a", a1 - a0, 3);
    chk("ld_spacing_b", a2 - a1, 3);
    drain();

    // Address wrap: the RAM decodes only the low 10 bits of the word address
    send(1, 0, 16'h0400 << ASH, 16'h1234, a0);
    chk("wrap_memaddr", memaddr, 16'h0400);
    drain();
    send(0, 0, 16'h0000, 16'h0, a0);
    drain();
    chk("wrap_ld_data", resp_data, 16'h1234);

`ifdef MEM_BYTE_ACCESS_EN
    // Byte read-modify-write and byte loads
    send(1, 0, 16'h0004, 16'hBEEF, a0);
    drain();
    send(1, 1, 16'h0005, 16'hFF5A, a0);
    chk("bst_memget", memget, 1);
    chk("bst_rd_memaddr", memaddr, 16'h0002);
    @(negedge clk);
    chk("bst_merge_nowr", memset, 0);
    @(negedge clk);
    chk("bst_memset", memset, 1);
    chk("bst_memaddr", memaddr, 16'h0002);
    chk("bst_memval", memval, 16'h5AEF);
    drain();
    send(0, 1, 16'h0004, 16'h0, a0);
    drain();
    chk("bld_lane0", resp_data, 16'h00EF);
    send(0, 1, 16'h0005, 16'h0, a0);
    drain();
    chk("bld_lane1", resp_data, 16'h005A);
`else
    // req_byte has no effect in the word-only build
    send(1, 1, 16'h0006, 16'hA5C3, a0);
    chk("wbyte_st_memval", memval, 16'hA5C3);
    drain();
    send(0, 1, 16'h0006, 16'h0, a0);
    drain();
    chk("wbyte_ld_data", resp_data, 16'hA5C3);
`endif

    // Random mixed traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      ra = W'($urandom_range(0, 15));
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
           W'($urandom), a0);
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); @(negedge clk); end
    end
    drain();

    // Asynchronous reset in the middle of WRITE
    wi = widx(16'h03F0 << ASH);
    saved = shadow[wi];
    send(1, 0, 16'h03F0 << ASH, 16'hDEAD, a0);
    chk("rw_memset_pre", memset, 1);
    c0 = cyc;
    #2 rst = 1'b1;
    #1;
    chk("rw_memset_async", memset, 0);
    chk("rw_no_edge", cyc, c0);
    sbq.delete();
    shadow[wi] = saved;
    last_load = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rw_ready", req_ready, 1);
    chk("rw_resp_valid", resp_valid, 0);
    chk("rw_resp_data", resp_data, 0);
    repeat (4) @(negedge clk);
    send(0, 0, 16'h03F0 << ASH, 16'h0, a0);
    drain();
    send(0, 0, 16'h0005 << ASH, 16'h0, a0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
